// File: rtl/rv_dbg_pkg.sv
// Shared run-control types: FSM states and breakpoint index sizing.
package rv_dbg_pkg;

    typedef enum logic [1:0] {
        DBG_HALT = 2'd0,
        DBG_RUN  = 2'd1,
        DBG_STEP = 2'd2
    } dbg_state_t;

    localparam int MAX_BP = 8;
    localparam int IDX_W  = 3;

endpackage

// File: rtl/dbg_debounce.sv
// Button conditioner: 2-flop synchroniser, level filtered on agreeing tick samples, 1-cycle press pulse.
// Latency: at most 2 ticks + 3 clocks from a stable raw level to the press pulse; no backpressure.
module dbg_debounce (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press
);

    logic sync0;
    logic sync1;
    logic sample;
    logic level_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            sample  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync0   <= raw;
            sync1   <= sync0;
            level_d <= level;
            if (tick) begin
                sample <= sync1;
                // level only follows once this sample matches the previous one
                if (sync1 == sample) begin
                    level <= sync1;
                end
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/rv_debug_ctrl.sv
// Run/halt/step control gating picorv32 mem_ready, with NUM_BP fetch/data address breakpoints.
// mem_ready is purely combinational (zero latency); the CPU is stalled whenever the FSM withholds ready.
module rv_debug_ctrl
    import rv_dbg_pkg::*;
#(
    parameter int NUM_BP       = 4,
    parameter int ADDR_W       = 32,
    parameter int LOG_DEBOUNCE = 18,
    parameter int LONG_TICKS   = 127
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_step,
    input  logic                     btn_run,
    input  logic                     btn_halt,
    input  logic                     mem_valid,
    input  logic                     mem_instr,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic                     slave_ready,
    output logic                     mem_ready,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP-1:0]        bp_data,
    output logic                     halted,
    output logic                     bp_hit,
    output logic [IDX_W-1:0]         bp_idx
);

    localparam logic [7:0] LONG_LIM = 8'(LONG_TICKS);

    dbg_state_t              state;
    logic                    skip;
    logic [LOG_DEBOUNCE-1:0] presc;
    logic                    tick;
    logic [7:0]              hold_cnt;

    logic step_level, step_press;
    logic run_level, run_press;
    logic halt_level, halt_press;
    logic step_rep;
    logic step_ev, run_ev, halt_ev;

    logic [NUM_BP-1:0] hit_vec;
    logic              match_any;
    logic [IDX_W-1:0]  match_idx;
    logic              bp_stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = &presc;

    dbg_debounce u_step (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (btn_step),
        .level (step_level),
        .press (step_press)
    );

    dbg_debounce u_run (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (btn_run),
        .level (run_level),
        .press (run_press)
    );

    dbg_debounce u_halt (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .raw   (btn_halt),
        .level (halt_level),
        .press (halt_press)
    );

    // Held step: count ticks (saturating), then fire one step per tick once the limit is reached
    always_ff @(posedge clk) begin
        if (reset || !step_level) begin
            hold_cnt <= 8'd0;
        end else if (tick && hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign step_rep = tick && step_level && (hold_cnt >= LONG_LIM);
    assign halt_ev  = halt_press;
    assign step_ev  = step_press || step_rep;
    assign run_ev   = run_press && run_level;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            hit_vec[i] = bp_en[i] && mem_valid
                         && (mem_addr == bp_addr[i*ADDR_W +: ADDR_W])
                         && (bp_data[i] ? !mem_instr : mem_instr);
        end
    end

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    assign bp_stop = (state == DBG_RUN) && match_any && !skip;

    always_comb begin
        mem_ready = 1'b0;
        case (state)
            DBG_STEP: mem_ready = slave_ready;
            DBG_RUN:  mem_ready = slave_ready && !bp_stop;
            default:  mem_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= DBG_HALT;
            halted <= 1'b1;
            bp_hit <= 1'b0;
            bp_idx <= '0;
            skip   <= 1'b0;
        end else begin
            if (mem_valid && mem_ready) begin
                skip <= 1'b0;
            end
            case (state)
                DBG_HALT: begin
                    if (halt_ev) begin
                        state <= DBG_HALT;
                    end else if (step_ev) begin
                        state  <= DBG_STEP;
                        halted <= 1'b0;
                        bp_hit <= 1'b0;
                    end else if (run_ev) begin
                        // resume past the breakpoint that stopped us
                        state  <= DBG_RUN;
                        halted <= 1'b0;
                        bp_hit <= 1'b0;
                        skip   <= 1'b1;
                    end
                end
                DBG_RUN: begin
                    if (halt_ev || bp_stop) begin
                        state  <= DBG_HALT;
                        halted <= 1'b1;
                    end
                    if (bp_stop) begin
                        bp_hit <= 1'b1;
                        bp_idx <= match_idx;
                    end
                end
                DBG_STEP: begin
                    if (halt_ev || (mem_valid && slave_ready)) begin
                        state  <= DBG_HALT;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state  <= DBG_HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_debug_ctrl.sv
// Self-checking bench for rv_debug_ctrl with a fast debounce tick (every 4 clocks) and LONG_TICKS=3.
module tb_rv_debug_ctrl;

    localparam int NUM_BP = 4;
    localparam int ADDR_W = 32;
    localparam int LT     = 3;
    localparam int TICK   = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     btn_step, btn_run, btn_halt;
    logic                     mem_valid, mem_instr, slave_ready, mem_ready;
    logic [ADDR_W-1:0]        mem_addr;
    logic [NUM_BP*ADDR_W-1:0] bp_addr;
    logic [NUM_BP-1:0]        bp_en, bp_data;
    logic                     halted, bp_hit;
    logic [2:0]               bp_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ncomp  = 0;

    logic [ADDR_W-1:0] ref_addr [NUM_BP];
    logic              ref_en   [NUM_BP];
    logic              ref_data [NUM_BP];

    rv_debug_ctrl #(
        .NUM_BP       (NUM_BP),
        .ADDR_W       (ADDR_W),
        .LOG_DEBOUNCE (2),
        .LONG_TICKS   (LT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_step    (btn_step),
        .btn_run     (btn_run),
        .btn_halt    (btn_halt),
        .mem_valid   (mem_valid),
        .mem_instr   (mem_instr),
        .mem_addr    (mem_addr),
        .slave_ready (slave_ready),
        .mem_ready   (mem_ready),
        .bp_addr     (bp_addr),
        .bp_en       (bp_en),
        .bp_data     (bp_data),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .bp_idx      (bp_idx)
    );

    always #5 clk = ~clk;

    // cycles since reset release; debounce ticks land on edges where cyc becomes a multiple of 4
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mem_valid && mem_ready) ncomp <= ncomp + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic int model_idx(input logic [ADDR_W-1:0] a, input logic instr, input logic valid);
        if (!valid) return -1;
        for (int i = 0; i < NUM_BP; i++) begin
            if (ref_en[i] && ref_addr[i] == a && (ref_data[i] ? !instr : instr)) return i;
        end
        return -1;
    endfunction

    task automatic apply_bp();
        for (int i = 0; i < NUM_BP; i++) begin
            bp_addr[i*ADDR_W +: ADDR_W] = ref_addr[i];
            bp_en[i]   = ref_en[i];
            bp_data[i] = ref_data[i];
        end
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        do drive_pt(); while (cyc % TICK != 0);
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_step = v;
            1:       btn_run  = v;
            default: btn_halt = v;
        endcase
    endtask

    // raw button held for exactly h debounce ticks, then released and allowed to settle
    task automatic hold_btn(input int which, input int h);
        wait_tick();
        set_btn(which, 1'b1);
        repeat (h) wait_tick();
        set_btn(which, 1'b0);
        repeat (4) wait_tick();
    endtask

    task automatic wait_halted(input logic v, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (halted === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic go_run(output bit ok);
        drive_pt();
        btn_run = 1'b1;
        wait_halted(1'b0, 60, ok);
        drive_pt();
        btn_run = 1'b0;
        repeat (4) wait_tick();
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        btn_step = 1'b0; btn_run = 1'b0; btn_halt = 1'b0;
        mem_valid = 1'b1; mem_instr = 1'b1; slave_ready = 1'b1;
        mem_addr = 32'h1000_0000 | ($urandom & 32'hFFFC);
        for (int i = 0; i < NUM_BP; i++) begin
            ref_addr[i] = 32'h2000_0000 | ($urandom & 32'hFFFC);
            ref_en[i] = 1'b0;
            ref_data[i] = 1'b0;
        end
        apply_bp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reset_halted got %b want 1", halted); end
        checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
        checks++; if (bp_idx !== 3'd0) begin errors++; $display("FAIL reset_bp_idx got %0d want 0", bp_idx); end
        drive_pt();
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (mem_ready !== 1'b0 || halted !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_halt bad_cycles got %0d want 0", bad); end
    endtask

    task automatic test_step_single();
        int n0, h;
        for (int t = 0; t < 3; t++) begin
            mem_addr = 32'h1000_0000 | ($urandom & 32'hFFFC);
            h = $urandom_range(2, LT);
            n0 = ncomp;
            hold_btn(0, h);
            checks++; if (ncomp - n0 != 1) begin errors++; $display("FAIL step_single h=%0d completions got %0d want 1", h, ncomp - n0); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step_single_halted got %b want 1", halted); end
        end
    endtask

    task automatic test_long_press();
        int n0, h, want;
        for (int t = 0; t < 2; t++) begin
            h = (t == 0) ? 9 : $urandom_range(LT + 1, 8);
            want = 1 + (h - LT);
            n0 = ncomp;
            hold_btn(0, h);
            checks++; if (ncomp - n0 != want) begin errors++; $display("FAIL long_press h=%0d completions got %0d want %0d", h, ncomp - n0, want); end
            checks++; if (halted !== 1'b1) begin errors++; $display("FAIL long_press_halted got %b want 1", halted); end
        end
    endtask

    task automatic test_breakpoint();
        bit ok;
        ref_addr[2] = 32'h100; ref_en[2] = 1'b1; ref_data[2] = 1'b0;
        apply_bp();
        mem_valid = 1'b1; mem_instr = 1'b1; slave_ready = 1'b1; mem_addr = 32'h400;
        drive_pt();
        btn_run = 1'b1;
        wait_halted(1'b0, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_enter_run timeout got halted=%b want 0", halted); end
        drive_pt();
        btn_run = 1'b0;
        repeat (3) begin
            drive_pt();
            mem_addr = 32'h1000_0000 | ($urandom & 32'hFFFC);
        end
        drive_pt();
        mem_addr = 32'h100;
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL bp_block_ready got %b want 0", mem_ready); end
        drive_pt();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted got %b want 1", halted); end
        checks++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit got %b want 1", bp_hit); end
        checks++; if (bp_idx !== 3'd2) begin errors++; $display("FAIL bp_idx got %0d want 2", bp_idx); end
        repeat (4) wait_tick();
        checks++; if (bp_hit !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL bp_sticky got hit=%b halted=%b want 1 1", bp_hit, halted); end
    endtask

    task automatic test_resume();
        bit ok;
        int n0;
        drive_pt();
        btn_run = 1'b1;
        wait_halted(1'b0, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL resume timeout got halted=%b want 0", halted); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL resume_ready got %b want 1", mem_ready); end
        checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL resume_bp_hit_clear got %b want 0", bp_hit); end
        drive_pt();
        btn_run = 1'b0;
        mem_addr = 32'h400;
        n0 = ncomp;
        repeat (5) drive_pt();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume_running got halted=%b want 0", halted); end
        checks++; if (ncomp - n0 != 5) begin errors++; $display("FAIL resume_flow completions got %0d want 5", ncomp - n0); end
        mem_addr = 32'h100;
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rehit_ready got %b want 0", mem_ready); end
        drive_pt();
        checks++; if (halted !== 1'b1 || bp_idx !== 3'd2) begin errors++; $display("FAIL rehit got halted=%b idx=%0d want 1 2", halted, bp_idx); end
        repeat (4) wait_tick();
    endtask

    task automatic test_data_mode();
        bit ok;
        int exp;
        logic sr, vld, ins;
        logic [ADDR_W-1:0] a;
        ref_addr[0] = 32'h200; ref_en[0] = 1'b1; ref_data[0] = 1'b1;
        ref_en[1] = 1'b0;
        ref_addr[3] = 32'h200; ref_en[3] = 1'b1; ref_data[3] = 1'b1;
        apply_bp();
        for (int t = 0; t < 16; t++) begin
            if (halted === 1'b1) begin
                mem_valid = 1'b0;
                go_run(ok);
                checks++; if (!ok) begin errors++; $display("FAIL data_run timeout trial %0d got halted=%b want 0", t, halted); end
                mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h400; slave_ready = 1'b1;
                drive_pt();
            end
            case (t)
                0: begin a = 32'h200; ins = 1'b1; vld = 1'b1; sr = 1'b1; end
                1: begin a = 32'h200; ins = 1'b0; vld = 1'b1; sr = 1'b1; end
                default: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h100;
                        1: a = 32'h200;
                        2: a = 32'h400;
                        default: a = 32'h3000_0000 | ($urandom & 32'hFFFC);
                    endcase
                    ins = 1'($urandom_range(0, 1));
                    vld = ($urandom_range(0, 3) != 0);
                    sr  = 1'($urandom_range(0, 1));
                end
            endcase
            mem_addr = a; mem_instr = ins; mem_valid = vld; slave_ready = sr;
            exp = model_idx(a, ins, vld);
            @(negedge clk);
            checks++; if (mem_ready !== ((exp >= 0) ? 1'b0 : sr)) begin errors++; $display("FAIL data_ready trial %0d a=%h i=%b got %b want %b", t, a, ins, mem_ready, (exp >= 0) ? 1'b0 : sr); end
            drive_pt();
            mem_valid = 1'b0;
            checks++; if (halted !== (exp >= 0)) begin errors++; $display("FAIL data_halt trial %0d a=%h i=%b got %b want %b", t, a, ins, halted, exp >= 0); end
            if (exp >= 0) begin
                checks++; if (bp_idx !== 3'(exp) || bp_hit !== 1'b1) begin errors++; $display("FAIL data_idx trial %0d got idx=%0d hit=%b want %0d 1", t, bp_idx, bp_hit, exp); end
            end
        end
    endtask

    task automatic test_halt_buttons();
        bit ok;
        int bad;
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h400; slave_ready = 1'b1;
        if (halted === 1'b1) begin
            go_run(ok);
            checks++; if (!ok) begin errors++; $display("FAIL halt_btn_run timeout got halted=%b want 0", halted); end
        end
        hold_btn(2, 2);
        checks++; if (halted !== 1'b1 || bp_hit !== 1'b0) begin errors++; $display("FAIL halt_btn got halted=%b hit=%b want 1 0", halted, bp_hit); end
        drive_pt();
        btn_halt = 1'b1; btn_run = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (halted !== 1'b1 || mem_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_run_together bad_cycles got %0d want 0", bad); end
        drive_pt();
        btn_halt = 1'b0; btn_run = 1'b0;
        repeat (4) wait_tick();
    endtask

    task automatic test_reset_mid_step();
        bit ok;
        mem_valid = 1'b0;
        drive_pt();
        btn_step = 1'b1;
        wait_halted(1'b0, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL step_wait timeout got halted=%b want 0", halted); end
        drive_pt();
        btn_step = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL step_waits_for_valid got halted=%b want 0", halted); end
        mem_valid = 1'b1; slave_ready = 1'b1; reset = 1'b1;
        @(negedge clk);
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL step_grant got %b want 1", mem_ready); end
        @(negedge clk);
        checks++; if (mem_ready !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL reset_mid_step got ready=%b halted=%b want 0 1", mem_ready, halted); end
        drive_pt();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_ready !== 1'b0 || bp_hit !== 1'b0) begin errors++; $display("FAIL post_reset got ready=%b hit=%b want 0 0", mem_ready, bp_hit); end
    endtask

    initial begin
        test_reset();
        test_step_single();
        test_long_press();
        test_breakpoint();
        test_resume();
        test_data_mode();
        test_halt_buttons();
        test_reset_mid_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
